// File: rtl/taylor_pkg.sv
// Shared fixed-point constants and state encoding for the cosine range-reduction
// stage and the Taylor/Horner core.
package taylor_pkg;

    localparam int WIDTH      = 24;
    localparam int FRAC       = 10;
    localparam int PI_FX      = 3217;
    localparam int HALF_PI_FX = 1608;
    localparam int TWO_PI_FX  = 6434;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_REDUCE,
        ST_FOLD_PI,
        ST_FOLD_HALF,
        ST_DONE
    } reduce_state_t;

    // Magnitude of a signed WIDTH-bit angle. The most negative code maps to 2^(WIDTH-1),
    // which is still representable as an unsigned WIDTH-bit value.
    function automatic logic [WIDTH-1:0] abs_angle(input logic [WIDTH-1:0] a);
        return a[WIDTH-1] ? (~a + 1'b1) : a;
    endfunction

endpackage

// File: rtl/angle_reduce_rtl.sv
// Reduces a signed angle to [0, pi/2] plus a cosine negate flag, with a fixed
// 14-cycle latency from an accepted start edge.
//
// state        | meaning
// ST_IDLE      | after reset, waiting for a start edge
// ST_LOAD      | capture |angle_in|, clear negate, drop ready_out
// ST_REDUCE    | restoring modulo 2*pi, k = 10 down to 0
// ST_FOLD_PI   | fold [pi, 2*pi) onto [0, pi), flip negate
// ST_FOLD_HALF | fold (pi/2, pi) onto (0, pi/2), register outputs
// ST_DONE      | result held, waiting for the next start edge
module angle_reduce_rtl
    import taylor_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] angle_in,
    output logic             ready_out,
    output logic [WIDTH-1:0] angle_out,
    output logic             negate_out
);

    reduce_state_t    state;
    reduce_state_t    state_next;
    logic             start_prev;
    logic             start_armed;
    logic             start_edge;
    logic [WIDTH-1:0] m;
    logic             neg;
    logic [3:0]       k;
    logic [WIDTH:0]   sub_val;
    logic             fold_half;

    // start_armed needs a low sample after reset, so a start already high at
    // reset release cannot be mistaken for a rising edge.
    assign start_edge = start && !start_prev && start_armed;
    assign sub_val    = (WIDTH+1)'(TWO_PI_FX) << k;
    assign fold_half  = m > WIDTH'(HALF_PI_FX);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            start_prev  <= 1'b0;
            start_armed <= 1'b0;
        end else begin
            state       <= state_next;
            start_prev  <= start;
            start_armed <= start_armed || !start;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (start_edge) state_next = ST_LOAD;
            ST_LOAD:      state_next = ST_REDUCE;
            ST_REDUCE:    if (k == 4'd0) state_next = ST_FOLD_PI;
            ST_FOLD_PI:   state_next = ST_FOLD_HALF;
            ST_FOLD_HALF: state_next = ST_DONE;
            ST_DONE:      if (start_edge) state_next = ST_LOAD;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            m          <= '0;
            neg        <= 1'b0;
            k          <= 4'd0;
            ready_out  <= 1'b0;
            angle_out  <= '0;
            negate_out <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    m         <= abs_angle(angle_in);
                    neg       <= 1'b0;
                    k         <= 4'd10;
                    ready_out <= 1'b0;
                end
                ST_REDUCE: begin
                    if ({1'b0, m} >= sub_val) begin
                        m <= m - sub_val[WIDTH-1:0];
                    end
                    k <= k - 4'd1;
                end
                ST_FOLD_PI: begin
                    if (m >= WIDTH'(PI_FX)) begin
                        m   <= m - WIDTH'(PI_FX);
                        neg <= ~neg;
                    end
                end
                ST_FOLD_HALF: begin
                    // Exactly pi/2 is left as is; cos is zero there either way.
                    if (fold_half) begin
                        m         <= WIDTH'(PI_FX) - m;
                        angle_out <= WIDTH'(PI_FX) - m;
                    end else begin
                        angle_out <= m;
                    end
                    neg        <= neg ^ fold_half;
                    negate_out <= neg ^ fold_half;
                    ready_out  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_angle_reduce_rtl.sv
// Self-checking bench for angle_reduce_rtl: table of angle vectors plus
// control-path sequences (ignored start, held start, mid-operation reset).
module tb_angle_reduce_rtl;

    localparam int LAT = 15;  // posedges from start drive to ready seen (edge + 14)

    typedef struct {
        logic [23:0] ang;
        logic [23:0] exp_ang;
        logic        exp_neg;
    } vec_t;

    typedef struct {
        logic [23:0] ang;
        logic        neg;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [23:0] angle_in = '0;
    logic        ready_out;
    logic [23:0] angle_out;
    logic        negate_out;

    int   tests = 0;
    int   fails = 0;
    int   rises = 0;
    logic ready_q = 1'b0;
    exp_t sb_q[$];
    vec_t vecs[12];

    angle_reduce_rtl dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .angle_in   (angle_in),
        .ready_out  (ready_out),
        .angle_out  (angle_out),
        .negate_out (negate_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        ready_q <= ready_out;
        if (ready_out && !ready_q) rises <= rises + 1;
    end

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Drives one start edge at a negedge and waits for the result.
    // hold: cycles start stays high; ignore_at: cycle of an extra start pulse (0 = none).
    task automatic run_op(input logic [23:0] a, input logic [23:0] ea, input logic en,
                          input int hold, input int ignore_at);
        int   cyc;
        logic seen_low;
        logic got;
        exp_t e;
        cyc      = 0;
        seen_low = 1'b0;
        got      = 1'b0;
        angle_in = a;
        start    = 1'b1;
        sb_q.push_back('{ang: ea, neg: en});
        while (cyc < 40 && !got) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
            if (cyc == hold) start = 1'b0;
            if (cyc == 3) angle_in = 24'($urandom);
            if (ignore_at != 0 && cyc == ignore_at) start = 1'b1;
            if (ignore_at != 0 && cyc == ignore_at + 1) start = 1'b0;
            if (!ready_out) seen_low = 1'b1;
            else if (seen_low) got = 1'b1;
        end
        check("latency", 24'(cyc), 24'(LAT));
        e = sb_q.pop_front();
        if (got) begin
            check("angle_out", angle_out, e.ang);
            check("negate_out", {23'd0, negate_out}, {23'd0, e.neg});
        end
        while (cyc < hold) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
            if (cyc == hold) start = 1'b0;
        end
    endtask

    initial begin
        int r0;
        int highs;

        vecs[0]  = '{ang: 24'd0,        exp_ang: 24'd0,    exp_neg: 1'b0};
        vecs[1]  = '{ang: 24'd1434,     exp_ang: 24'd1434, exp_neg: 1'b0};
        vecs[2]  = '{ang: 24'd2048,     exp_ang: 24'd1169, exp_neg: 1'b1};
        vecs[3]  = '{ang: 24'hFFF800,   exp_ang: 24'd1169, exp_neg: 1'b1};
        vecs[4]  = '{ang: 24'd4096,     exp_ang: 24'd879,  exp_neg: 1'b1};
        vecs[5]  = '{ang: 24'd643500,   exp_ang: 24'd100,  exp_neg: 1'b0};
        vecs[6]  = '{ang: 24'h800000,   exp_ang: 24'd1328, exp_neg: 1'b0};
        vecs[7]  = '{ang: 24'd1608,     exp_ang: 24'd1608, exp_neg: 1'b0};
        vecs[8]  = '{ang: 24'd3217,     exp_ang: 24'd0,    exp_neg: 1'b1};
        vecs[9]  = '{ang: 24'd6433,     exp_ang: 24'd1,    exp_neg: 1'b0};
        vecs[10] = '{ang: 24'd6434,     exp_ang: 24'd0,    exp_neg: 1'b0};
        vecs[11] = '{ang: 24'hFFFFFF,   exp_ang: 24'd1,    exp_neg: 1'b0};

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("reset ready_out", {23'd0, ready_out}, 24'd0);
        check("reset angle_out", angle_out, 24'd0);
        check("reset negate_out", {23'd0, negate_out}, 24'd0);
        @(negedge clock);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].ang, vecs[i].exp_ang, vecs[i].exp_neg, 1, 0);
            repeat (2) @(negedge clock);
        end

        // Extra start edge mid-operation is ignored and does not retrigger later.
        run_op(24'd4096, 24'd879, 1'b1, 1, 5);
        highs = 0;
        repeat (20) begin
            @(negedge clock);
            if (ready_out) highs++;
        end
        check("ignored start no retrigger", 24'(highs), 24'd20);

        // Start held high for 40 cycles yields exactly one result.
        r0 = rises;
        run_op(24'd2048, 24'd1169, 1'b1, 40, 0);
        repeat (5) @(negedge clock);
        check("held start result count", 24'(rises - r0), 24'd1);

        // Reset at cycle 7 of an operation discards it.
        angle_in = 24'd4096;
        start    = 1'b1;
        repeat (7) begin
            @(posedge clock);
            @(negedge clock);
            start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("midop reset ready_out", {23'd0, ready_out}, 24'd0);
        check("midop reset angle_out", angle_out, 24'd0);
        check("midop reset negate_out", {23'd0, negate_out}, 24'd0);
        reset = 1'b0;
        highs = 0;
        repeat (20) begin
            @(negedge clock);
            if (ready_out) highs++;
        end
        check("midop reset no result", 24'(highs), 24'd0);
        run_op(24'd643500, 24'd100, 1'b0, 1, 0);

        // Start already high through reset release must not trigger.
        @(negedge clock);
        start = 1'b1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        highs = 0;
        repeat (20) begin
            @(negedge clock);
            if (ready_out) highs++;
        end
        check("start high at reset release", 24'(highs), 24'd0);
        start = 1'b0;
        @(negedge clock);
        run_op(24'h800000, 24'd1328, 1'b0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/angle_reduce_rtl.md
# angle_reduce_rtl

Upstream range-reduction stage for the Taylor/Horner cosine core. Accepts an arbitrary signed angle in 24-bit fixed point (10 fractional bits) and reduces it, using cos evenness, 2π periodicity and quadrant symmetry, to a magnitude in [0, π/2]. It also produces a flag that tells the downstream stage to negate the cosine. Its `angle_out` feeds the core's `angle_in` directly; `ready_out` gates the core's `start`.

## Interface
- `WIDTH`, 24: data width of `angle_in` and `angle_out`.
- `FRAC`, 10: fractional bits; the scale is 1024.
- `clock` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request; only a rising edge is acted on.
- `angle_in` in 24: signed two's-complement angle in radians; range [-8192.0, 8191.999].
- `ready_out` out 1: result valid and block idle; held until the next accepted start.
- `angle_out` out 24: unsigned reduced angle in [0, HALF_PI_FX].
- `negate_out` out 1: 1 means the downstream cosine must be negated.

## Operation
- Constants: PI_FX = 3217, HALF_PI_FX = 1608, TWO_PI_FX = 6434.
- States and transitions:
  - IDLE (after reset) → LOAD when `start` is 1 and was 0 on the previous cycle.
  - LOAD → REDUCE.
  - REDUCE → FOLD_PI after 11 steps (k = 10 down to 0).
  - FOLD_PI → FOLD_HALF.
  - FOLD_HALF → DONE.
  - DONE → LOAD on the next start edge.
- LOAD:
  - Register `m = |angle_in|` as a 24-bit unsigned value. -8388608 maps to 8388608 with no overflow.
  - Clear the negate register.
  - Drop `ready_out`.
- REDUCE (restoring modulo): if `m >= TWO_PI_FX << k`, then `m -= TWO_PI_FX << k`. Use a 25-bit compare; the result is m in [0, 6433].
- FOLD_PI: if `m >= PI_FX`, then `m -= PI_FX` and negate flips.
- FOLD_HALF:
  - If `m > HALF_PI_FX`, then `m = PI_FX - m` and negate flips.
  - `m == HALF_PI_FX` is left unchanged.
  - Register `angle_out` and `negate_out`, and set `ready_out`.
- Start edges in LOAD, REDUCE or either FOLD state are ignored, and the edge detector still updates.
- `angle_in` is sampled only in LOAD. Later changes do not affect the result in flight.
- Arithmetic is unsigned after LOAD. No intermediate value goes negative or exceeds 25 bits.

## Timing
- Reset values:
  - `ready_out` = 0, `angle_out` = 0, `negate_out` = 0.
  - State = IDLE; the previous-start register = 0.
- Start edge sampled at posedge N:
  - LOAD executes at N+1.
  - REDUCE runs at N+2 … N+12.
  - FOLD_PI runs at N+13.
  - FOLD_HALF runs at N+14.
- `ready_out` rises after posedge N+14. Fixed latency is 14 cycles, independent of the data.
- `angle_out` and `negate_out` are stable whenever `ready_out` = 1. They change only at FOLD_HALF.
- `start` held high across DONE does not retrigger. A new low→high transition is required.
- Reset asserted in any state:
  - Next edge: IDLE with all outputs 0.
  - The in-flight result is discarded.
  - The start edge detector is cleared, so a `start` already high at reset release does not trigger. It must go low, then high.

## Structure
- Shared package `taylor_pkg`, also used by `taylor_horner_rtl`:
  - `WIDTH`, `FRAC`.
  - `PI_FX`, `HALF_PI_FX`, `TWO_PI_FX`.
  - State enum `reduce_state_t`.
- No sub-module is required. The conditional subtract is one `always_ff` arm indexed by the step counter k (4 bits).
- The top-level cosine wrapper instantiates this block followed by the core. The wrapper applies `negate_out` to `cos_out`.

## Test plan
- `angle_in` = 0, start pulse → after 14 cycles `ready_out` = 1, `angle_out` = 0, `negate_out` = 0.
- `angle_in` = 1434 (1.4) → `angle_out` = 1434, neg = 0.
- `angle_in` = 2048 (2.0) → 1169, neg = 1. With `angle_in` = -2048 → identical result.
- `angle_in` = 4096 (4.0) → 879, neg = 1.
- `angle_in` = 643500 (100·2π + 100 LSB) → 100, neg = 0.
- `angle_in` = 0x800000 (most negative) → 1328, neg = 0.
- `angle_in` = 1608 → 1608, neg = 0 (fold boundary untouched).
- Control behaviour:
  - A start edge at cycle 5 of an operation → ignored; result and latency unchanged.
  - `start` held high for 40 cycles → exactly one result.
  - Reset at cycle 7 of an operation → all outputs 0 next cycle, no `ready_out`; the next clean start edge then gives a correct result.
